// File: rtl/ex_mem_pkg.sv
// Shared definitions for the execute-to-memory pipeline stage.
//   - XLEN/REGW defaults for the 64-bit core
//   - state encoding of the two-entry skid buffer
//   - bit positions inside the 5-bit control bundle
package ex_mem_pkg;

    localparam int unsigned XLEN_DEF = 64;
    localparam int unsigned REGW_DEF = 5;

    // Skid-buffer occupancy encoding
    localparam logic [1:0] ST_EMPTY_ENC = 2'd0;
    localparam logic [1:0] ST_ONE_ENC   = 2'd1;
    localparam logic [1:0] ST_FULL_ENC  = 2'd2;

    typedef enum logic [1:0] {
        StEmpty = ST_EMPTY_ENC,
        StOne   = ST_ONE_ENC,
        StFull  = ST_FULL_ENC
    } skid_state_e;

    // ctrl = {branch, mem_read, mem_write, reg_write, mem_to_reg}
    localparam int unsigned BR  = 4;
    localparam int unsigned MR  = 3;
    localparam int unsigned MW  = 2;
    localparam int unsigned RW  = 1;
    localparam int unsigned M2R = 0;

    localparam int unsigned CTRL_W     = 5;
    localparam int unsigned OUT_CTRL_W = 4;

endpackage

// File: rtl/skid_buffer2.sv
// Two-entry skid buffer with a registered in_ready.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   flush               synchronous kill of both entries; also drops any offered beat
//   in_valid/in_ready   upstream handshake (in_ready comes straight from a flop)
//   in_data             payload captured on accept
//   out_valid/out_ready downstream handshake
//   out_data            payload of the main entry
module skid_buffer2
    import ex_mem_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skid_state_e      state_q, state_d;
    logic             in_ready_q;
    logic [WIDTH-1:0] main_q, skid_q;

    logic accept, present;
    logic load_main_in, load_main_skid, load_skid;

    // flush overrides both handshakes
    assign accept  = in_valid && in_ready_q && !flush;
    assign present = out_valid && out_ready && !flush;

    // State register; in_ready is precomputed from the next state so it is a pure flop output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != StFull);
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: if (accept) state_d = StOne;
                StOne: begin
                    if (accept && !present)      state_d = StFull;
                    else if (!accept && present) state_d = StEmpty;
                end
                StFull:  if (present) state_d = StOne;
                default: state_d = StEmpty;
            endcase
        end
    end

    // Output / datapath-control logic
    always_comb begin
        out_valid      = (state_q != StEmpty);
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state_q)
            StEmpty: load_main_in = accept;
            StOne: begin
                load_main_in = accept && present;
                load_skid    = accept && !present;
            end
            StFull:  load_main_skid = present;
            default: ;
        endcase
    end

    // Entries only change on capture, so out_data is stable under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in)        main_q <= in_data;
            else if (load_main_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= in_data;
        end
    end

    assign in_ready = in_ready_q;
    assign out_data = main_q;

endmodule

// File: rtl/ex_mem_stage.sv
// Execute-to-memory pipeline stage.
// Buffers ALU result, store data, rd and memory/writeback control through a two-entry
// skid buffer and resolves conditional branches at accept time.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   flush                      drop all buffered beats and the beat offered this cycle
//   in_valid/in_ready          upstream handshake
//   alu_result, alu_zero       ALU64 outputs
//   rs2_data, pc, imm, rd      store data, PC, halfword branch offset, destination reg
//   ctrl                       {branch, mem_read, mem_write, reg_write, mem_to_reg}
//   out_valid/out_ready        downstream handshake
//   out_result, out_store_data, out_rd, out_ctrl  main-entry payload
//   redirect, redirect_pc      one-cycle taken-branch pulse and target
module ex_mem_stage
    import ex_mem_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned REGW = REGW_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [XLEN-1:0]       alu_result,
    input  logic                  alu_zero,
    input  logic [XLEN-1:0]       rs2_data,
    input  logic [XLEN-1:0]       pc,
    input  logic [XLEN-1:0]       imm,
    input  logic [REGW-1:0]       rd,
    input  logic [CTRL_W-1:0]     ctrl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_result,
    output logic [XLEN-1:0]       out_store_data,
    output logic [REGW-1:0]       out_rd,
    output logic [OUT_CTRL_W-1:0] out_ctrl,
    output logic                  redirect,
    output logic [XLEN-1:0]       redirect_pc
);

    localparam int unsigned PAYLOAD_W = 2 * XLEN + REGW + OUT_CTRL_W;

    logic [PAYLOAD_W-1:0] in_payload, out_payload;
    logic                 accept, taken;
    logic [XLEN-1:0]      target;
    logic                 redirect_q;
    logic [XLEN-1:0]      redirect_pc_q;

    // The branch bit is consumed here and not forwarded to the memory stage
    assign in_payload = {alu_result, rs2_data, rd, ctrl[MR:M2R]};
    assign {out_result, out_store_data, out_rd, out_ctrl} = out_payload;

    skid_buffer2 #(
        .WIDTH(PAYLOAD_W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_payload),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_payload)
    );

    // A beat dropped by flush never redirects
    assign accept = in_valid && in_ready && !flush;
    assign taken  = accept && ctrl[BR] && alu_zero;
    // imm counts halfwords; the sum wraps modulo 2^XLEN
    assign target = pc + (imm << 1);

    // A redirect already registered is unaffected by flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            redirect_q <= taken;
            if (taken) redirect_pc_q <= target;
        end
    end

    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] alu_result = '0;
    logic        alu_zero = 1'b0;
    logic [63:0] rs2_data = '0;
    logic [63:0] pc = '0;
    logic [63:0] imm = '0;
    logic [4:0]  rd = '0;
    logic [4:0]  ctrl = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_result;
    logic [63:0] out_store_data;
    logic [4:0]  out_rd;
    logic [3:0]  out_ctrl;
    logic        redirect;
    logic [63:0] redirect_pc;

    ex_mem_stage #(
        .XLEN(64),
        .REGW(5)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero),
        .rs2_data      (rs2_data),
        .pc            (pc),
        .imm           (imm),
        .rd            (rd),
        .ctrl          (ctrl),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_store_data(out_store_data),
        .out_rd        (out_rd),
        .out_ctrl      (out_ctrl),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] res;
        logic [63:0] sd;
        logic [4:0]  rd;
        logic [3:0]  ctrl;
    } beat_t;

    // Reference model: a FIFO of at most two beats plus the pending redirect
    beat_t       exp_q[$];
    logic        exp_redir = 1'b0;
    logic [63:0] exp_rpc = '0;
    logic        mon_acc;
    beat_t       mon_beat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: inputs change just after posedge, so at negedge both the
    // DUT outputs and the inputs about to be sampled are stable
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_redir = 1'b0;
            exp_rpc   = '0;
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd1);
            chk("rst_redirect", 64'(redirect), 64'd0);
            chk("rst_redirect_pc", redirect_pc, 64'd0);
            chk("rst_out_result", out_result, 64'd0);
            chk("rst_out_store_data", out_store_data, 64'd0);
            chk("rst_out_rd", 64'(out_rd), 64'd0);
            chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        end else begin
            chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
            chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                chk("out_result", out_result, exp_q[0].res);
                chk("out_store_data", out_store_data, exp_q[0].sd);
                chk("out_rd", 64'(out_rd), 64'(exp_q[0].rd));
                chk("out_ctrl", 64'(out_ctrl), 64'(exp_q[0].ctrl));
            end
            chk("redirect", 64'(redirect), 64'(exp_redir));
            if (exp_redir) chk("redirect_pc", redirect_pc, exp_rpc);

            mon_acc = in_valid && (exp_q.size() < 2) && !flush;
            if (flush) begin
                exp_q.delete();
            end else begin
                if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
                if (mon_acc) begin
                    mon_beat.res  = alu_result;
                    mon_beat.sd   = rs2_data;
                    mon_beat.rd   = rd;
                    mon_beat.ctrl = ctrl[3:0];
                    exp_q.push_back(mon_beat);
                end
            end
            exp_redir = mon_acc && ctrl[4] && alu_zero;
            if (exp_redir) exp_rpc = pc + imm * 64'd2;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [63:0] r, input logic [63:0] sd, input logic [63:0] p,
                            input logic [63:0] im, input logic [4:0] d, input logic [4:0] c,
                            input logic z);
        in_valid   = 1'b1;
        alu_result = r;
        rs2_data   = sd;
        pc         = p;
        imm        = im;
        rd         = d;
        ctrl       = c;
        alu_zero   = z;
    endtask

    // Hold the beat until it is taken, bounded
    task automatic offer(input logic [63:0] r, input logic [63:0] sd, input logic [63:0] p,
                         input logic [63:0] im, input logic [4:0] d, input logic [4:0] c,
                         input logic z);
        logic seen;
        logic done;
        done = 1'b0;
        set_beat(r, sd, p, im, d, c, z);
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            seen = in_ready;
            cyc();
            if (seen) done = 1'b1;
        end
        in_valid = 1'b0;
        chk("offer_accepted", 64'(done), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        #22 rst_n = 1'b1;
        cyc();

        // Single beat
        out_ready = 1'b1;
        offer(64'h10, 64'h0, 64'h0, 64'h0, 5'd5, 5'b00010, 1'b0);
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_result", out_result, 64'h10);
        chk("single_rd", 64'(out_rd), 64'd5);
        cyc();
        chk("single_drained", 64'(out_valid), 64'd0);

        // Backpressure: A, B accepted, C held until out_ready rises
        out_ready = 1'b0;
        offer(64'hA1, 64'hA2, 64'h0, 64'h0, 5'd1, 5'b01010, 1'b0);
        offer(64'hB1, 64'hB2, 64'h0, 64'h0, 5'd2, 5'b00100, 1'b0);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        set_beat(64'hC1, 64'hC2, 64'h0, 64'h0, 5'd3, 5'b00011, 1'b0);
        cyc();
        cyc();
        chk("bp_c_held", 64'(in_ready), 64'd0);
        chk("bp_front_is_a", out_result, 64'hA1);
        out_ready = 1'b1;
        offer(64'hC1, 64'hC2, 64'h0, 64'h0, 5'd3, 5'b00011, 1'b0);
        repeat (4) cyc();
        chk("bp_drained", 64'(out_valid), 64'd0);

        // Taken branch, not-taken branch, wrap-around target
        offer(64'h0, 64'h0, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFC, 5'd0, 5'b10000, 1'b1);
        chk("br_redirect", 64'(redirect), 64'd1);
        chk("br_target", redirect_pc, 64'h0FF8);
        cyc();
        chk("br_one_cycle", 64'(redirect), 64'd0);
        offer(64'h1, 64'h0, 64'h1000, 64'hFFFF_FFFF_FFFF_FFFC, 5'd0, 5'b10000, 1'b0);
        chk("br_not_taken", 64'(redirect), 64'd0);
        offer(64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h4, 5'd0, 5'b10000, 1'b1);
        chk("wrap_redirect", 64'(redirect), 64'd1);
        chk("wrap_target", redirect_pc, 64'h4);
        repeat (3) cyc();

        // Flush while FULL with a taken-branch beat offered in the same cycle
        out_ready = 1'b0;
        offer(64'hD1, 64'hD2, 64'h0, 64'h0, 5'd7, 5'b00010, 1'b0);
        offer(64'hE1, 64'hE2, 64'h0, 64'h0, 5'd8, 5'b00010, 1'b0);
        set_beat(64'hF1, 64'hF2, 64'h2000, 64'h10, 5'd9, 5'b10000, 1'b1);
        flush = 1'b1;
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        chk("flush_no_redirect", 64'(redirect), 64'd0);
        out_ready = 1'b1;
        repeat (3) cyc();
        chk("flush_no_ghost", 64'(out_valid), 64'd0);

        // Async reset while FULL with a redirect pending
        out_ready = 1'b0;
        offer(64'h51, 64'h52, 64'h0, 64'h0, 5'd10, 5'b00110, 1'b0);
        offer(64'h61, 64'h62, 64'h3000, 64'h8, 5'd11, 5'b10000, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("areset_out_valid", 64'(out_valid), 64'd0);
        chk("areset_in_ready", 64'(in_ready), 64'd1);
        chk("areset_redirect", 64'(redirect), 64'd0);
        chk("areset_redirect_pc", redirect_pc, 64'd0);
        chk("areset_out_result", out_result, 64'd0);
        chk("areset_out_store_data", out_store_data, 64'd0);
        chk("areset_out_rd", 64'(out_rd), 64'd0);
        chk("areset_out_ctrl", 64'(out_ctrl), 64'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        cyc();

        // Randomized traffic
        repeat (400) begin
            in_valid   = ($urandom_range(0, 9) < 7);
            out_ready  = ($urandom_range(0, 9) < 7);
            flush      = ($urandom_range(0, 19) == 0);
            alu_result = {$urandom, $urandom};
            rs2_data   = {$urandom, $urandom};
            pc         = {$urandom, $urandom};
            imm        = {$urandom, $urandom};
            rd         = 5'($urandom);
            ctrl       = 5'($urandom);
            alu_zero   = 1'($urandom);
            cyc();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (5) cyc();
        chk("final_drained", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

- Execute-to-memory pipeline stage of the 64-bit RISC-V core.
- Captures ALU64's `Result`/`zero` together with the instruction's store data, destination register, PC, immediate and control bits.
- Resolves conditional branches and presents one registered beat per instruction to the memory stage through a valid/ready handshake.
- A two-entry skid buffer gives full throughput with a fully registered `in_ready`.

## Interface
- `XLEN`, 64, datapath width
- `REGW`, 5, register-index width
- `clk` in 1: single rising-edge clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `flush` in 1: synchronous kill of all buffered beats.
- `in_valid` in 1: upstream beat valid.
- `in_ready` out 1: stage can accept a beat.
- `alu_result` in XLEN: ALU64 `Result`.
- `alu_zero` in 1: ALU64 `zero`. For ALUOp 1000 it is 1 when a<b.
- `rs2_data` in XLEN: store data.
- `pc` in XLEN: instruction PC.
- `imm` in XLEN: sign-extended branch offset, in halfwords.
- `rd` in REGW: destination register.
- `ctrl` in 5: {branch, mem_read, mem_write, reg_write, mem_to_reg}.
- `out_valid` out 1: downstream beat valid.
- `out_ready` in 1: memory stage accepts.
- `out_result`, `out_store_data` out XLEN.
- `out_rd` out REGW.
- `out_ctrl` out 4: {mem_read, mem_write, reg_write, mem_to_reg}.
- `redirect` out 1: one-cycle taken-branch pulse.
- `redirect_pc` out XLEN: branch target.

## Operation
- Accept a beat when `in_valid && in_ready`. Present a beat when `out_valid && out_ready`.
- States:
  - EMPTY: no entry.
  - ONE: main entry only.
  - FULL: main and skid entries.
- Transitions:
  - EMPTY -> ONE on accept.
  - ONE -> EMPTY on present without accept.
  - ONE stays ONE on accept and present together.
  - ONE -> FULL on accept without present. The new beat goes to skid.
  - FULL -> ONE on present. The skid entry moves to main.
- `in_ready` = (state != FULL), driven from a register.
- `out_valid` = (state != EMPTY). Outputs reflect the main entry.
- Branch resolution happens on accept, before buffering:
  - taken = `ctrl.branch && alu_zero`.
  - target = `pc + (imm << 1)`, truncated to XLEN; wrap-around is allowed.
  - A taken branch sets `redirect` for exactly the next cycle, with `redirect_pc` = target.
  - A branch beat is still buffered with reg_write/mem bits as provided. Decode supplies them as 0.
- `flush`:
  - Next state is EMPTY.
  - A beat offered in the same cycle is dropped.
  - `redirect` is not generated for a dropped beat.
  - A redirect already registered still fires.
- `flush` wins over any simultaneous accept or present.
- Data registers update only on capture. Outputs are stable while `out_valid && !out_ready`.

## Timing
- Latency is 1 cycle from accept to `out_valid` when the stage is EMPTY or presenting.
- Throughput is 1 beat/cycle with `out_ready` held high.
- Reset (async assert, sync-released by the top level):
  - state EMPTY; `in_ready`=1; `out_valid`=0; `redirect`=0.
  - All data outputs, `redirect_pc`, `out_rd` and `out_ctrl` are 0.
- Reset mid-operation discards both entries and any pending redirect.
- `out_valid`, once high, stays high until accepted or flushed.

## Structure
- Package `ex_mem_pkg`:
  - state encoding localparams.
  - ctrl bit-index localparams (BR, MR, MW, RW, M2R).
  - XLEN/REGW defaults.
- Sub-module `skid_buffer2`, parameterised by payload width, holds the state machine and both entries.
- The top level packs and unpacks the payload and owns branch resolution and the redirect register.

## Test plan
- Reset then a single beat:
  - Reset: all outputs 0 and `in_ready`=1.
  - Beat: `alu_result`=0x10, rd=5, reg_write=1, `out_ready`=1 -> next cycle `out_valid`=1, `out_result`=0x10, `out_rd`=5; `out_valid`=0 the cycle after.
- Backpressure:
  - Stimulus: `out_ready`=0, three consecutive offered beats A, B, C.
  - A and B accepted; `in_ready`=0 from cycle 2; C held.
  - Raising `out_ready` -> A, B, C presented in order with no loss or duplication.
- Taken branch:
  - Stimulus: branch=1, `alu_zero`=1, pc=0x1000, imm=-4.
  - Next cycle `redirect`=1, `redirect_pc`=0x0FF8, for one cycle only.
  - With `alu_zero`=0, `redirect` stays 0.
- Wrap-around: pc=0xFFFF_FFFF_FFFF_FFFC, imm=4 -> `redirect_pc`=0x4.
- Flush with simultaneous accept:
  - Stimulus: FULL state, `flush`=1 and `in_valid`=1 in the same cycle.
  - Next cycle `out_valid`=0 and `in_ready`=1; the offered beat never appears.
- Async reset while FULL: drop `rst_n` mid-cycle -> outputs go to reset values immediately, without waiting for a clock edge.
